cmp_mc: RTL and testbench
=========================

# cmp_mc

Parametrised multi-cycle compare unit for the ALU datapath. It computes set-on-compare results (greater/less/equal, signed or unsigned) for N-bit operands. Internally it runs a borrow-chained subtraction CHUNK bits per cycle, so wide compares can trade latency for area. Results are zero-extended to N bits for direct write-back, and lt/eq/gt flags are exported for branch logic.

## Interface
- N, default 32: operand and result width.
- CHUNK, default 8: bits subtracted per cycle. Requires 1 ≤ CHUNK ≤ N and N % CHUNK == 0. NCH = N/CHUNK.
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; sampled only when not busy.
- mode  input  3  compare operation, captured with start.
- A, B  input  N  operands, captured with start.
- busy  output  1  operation in progress.
- valid  output  1  one-cycle result strobe.
- C  output  N  result: {N-1 zeros, cond}.
- lt, eq, gt  output  1 each  relation of A to B under the captured signedness.

## Operation
- Modes:
  - 000 SGTU: A>B unsigned.
  - 001 SGT: signed.
  - 010 SLTU.
  - 011 SLT.
  - 100 SEQ.
  - 101 SNE.
  - 110 SGEU.
  - 111 SGE.
  - Signed modes are those with mode[0]=1 and mode[2:1]≠10. SEQ and SNE ignore signedness.
- Capture: on an accepted start, A and B are latched. For signed modes, the MSB of both operands is inverted at capture, which reduces the signed compare to an unsigned one.
- Per RUN cycle, chunk i (LSB first, i = 0..NCH-1):
  - compute B[i] − A[i] − borrow. The borrow register starts at 0.
  - neq |= |(A[i]^B[i]).
- After the last chunk:
  - gt = final borrow.
  - eq = ~neq.
  - lt = ~gt & ~eq.
  - cond is selected by mode from {gt, lt, eq}.
- FSM states:
  - IDLE: start → RUN (capture).
  - RUN: chunk counter 0..NCH-1; at NCH-1 → DONE, and C and flags are registered.
  - DONE: valid=1. If start is high → RUN (capture, back-to-back); otherwise → IDLE.
- start in RUN is ignored: no capture, no queueing.
- C, lt, eq, gt hold their last result until the next DONE. They are not cleared by a new start.
- Reset:
  - state=IDLE; busy, valid, C, lt, eq, gt, the counter and the borrow register all = 0.
  - Reset mid-RUN aborts the operation. No valid is produced and prior outputs are zeroed.
  - Reset dominates a simultaneous start.

## Timing
- start sampled high at edge k (in IDLE or DONE):
  - busy is high in the NCH cycles following edges k..k+NCH-1.
  - valid is high in the single cycle following edge k+NCH.
- Latency from start edge to valid: NCH+1 cycles.
- Throughput with continuous start: one result every NCH+1 cycles.
- busy and valid are never high together.
- NCH=1 (CHUNK=N): one RUN cycle, then DONE.
- mode, A and B are don't-care outside the capture edge.

## Structure
- Package cmp_pkg holds:
  - mode encodings (CMP_SGTU…CMP_SGE) and a signed-mode function;
  - state encoding IDLE/RUN/DONE.
- Sub-module sub_chunk #(W): W-bit subtractor.
  - Inputs: x, y, bin.
  - Outputs: diff, bout.
  - Instantiated once with W=CHUNK; operand chunks are muxed by the counter.
- Top: FSM, capture registers, counter ($clog2(NCH) bits, minimum 1), borrow/neq registers, result mux.
- Parameter legality is checked at elaboration with a fatal error.

## Test plan
- N=8, CHUNK=4: A=05, B=03, SGTU, start at edge k → valid in cycle after k+2, C=01, gt=1, lt=0, eq=0.
- N=8, CHUNK=4: A=80, B=01 → SGT gives C=00, lt=1; SGTU gives C=01, gt=1; SLT gives C=01.
- A=B=A5 (N=8) → SEQ C=01; SGE C=01; SGT C=00; SNE C=00; eq=1.
- start at k, second start with A=00 at k+1 (busy) → exactly one valid, carrying the first operation's result; no second result.
- rst high at edge k+1 during RUN → busy=0, no valid, C=00, flags 0; a new op afterwards completes normally.
- start held high continuously, N=32, CHUNK=8 → valid every 5 cycles; results match the operand sequence. Also run N=32, CHUNK=32 with SGE on 7FFFFFFF vs 80000000 → C=1 after 2 cycles.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: mode encodings, FSM states and signed-mode helper for cmp_mc
package cmp_pkg;
    typedef enum logic [2:0] {
        CMP_SGTU = 3'b000,
        CMP_SGT  = 3'b001,
        CMP_SLTU = 3'b010,
        CMP_SLT  = 3'b011,
        CMP_SEQ  = 3'b100,
        CMP_SNE  = 3'b101,
        CMP_SGEU = 3'b110,
        CMP_SGE  = 3'b111
    } cmp_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // SEQ/SNE share the odd-bit encoding but never need the MSB flip
    function automatic logic is_signed(input logic [2:0] m);
        return m[0] && (m[2:1] != 2'b10);
    endfunction
endpackage

// File: rtl/sub_chunk.sv
// sub_chunk: W-bit subtractor x - y - bin with borrow out
module sub_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);
    assign {bout, diff} = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bin};
endmodule

// File: rtl/cmp_mc.sv
// cmp_mc: multi-cycle set-on-compare unit, CHUNK bits of B-A per cycle, LSB first
module cmp_mc
    import cmp_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         valid,
    output logic [N-1:0] C,
    output logic         lt,
    output logic         eq,
    output logic         gt
);
    localparam int NCH = N / CHUNK;
    localparam int CW  = NCH > 1 ? $clog2(NCH) : 1;

    if (CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_param
        $fatal(1, "cmp_mc: illegal N=%0d CHUNK=%0d", N, CHUNK);
    end

    state_e         state, nxt;
    logic [N-1:0]   a_r, b_r;
    logic [2:0]     mode_r;
    logic [CW-1:0]  cnt;
    logic           brw, neq;
    logic [CHUNK-1:0] xa, xb, diff;
    logic           bout, last, cap, fgt, feq, flt, cond;

    assign xa = a_r[int'(cnt)*CHUNK +: CHUNK];
    assign xb = b_r[int'(cnt)*CHUNK +: CHUNK];

    sub_chunk #(.W(CHUNK)) u_sub (
        .x   (xb),
        .y   (xa),
        .bin (brw),
        .diff(diff),
        .bout(bout)
    );

    // the chained chunk differences are the chunks of B-A, so all-zero means A==B
    assign last = cnt == CW'(NCH - 1);
    assign cap  = start && state != RUN;
    assign fgt  = bout;
    assign feq  = ~(neq | (|diff));
    assign flt  = ~fgt & ~feq;
    assign cond = mode_r[2:1] == 2'b00 ? fgt :
                  mode_r[2:1] == 2'b01 ? flt :
                  mode_r == CMP_SEQ    ? feq :
                  mode_r == CMP_SNE    ? ~feq : ~flt;

    always_comb begin
        nxt   = state;
        busy  = state == RUN;
        valid = state == DONE;
        case (state)
            IDLE:    nxt = start ? RUN : IDLE;
            RUN:     nxt = last ? DONE : RUN;
            DONE:    nxt = start ? RUN : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            mode_r <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            neq    <= 1'b0;
            C      <= '0;
            lt     <= 1'b0;
            eq     <= 1'b0;
            gt     <= 1'b0;
        end else begin
            state <= nxt;
            if (cap) begin
                // flipping both MSBs turns a signed compare into an unsigned one
                a_r         <= A;
                b_r         <= B;
                a_r[N-1]    <= A[N-1] ^ is_signed(mode);
                b_r[N-1]    <= B[N-1] ^ is_signed(mode);
                mode_r      <= mode;
                cnt         <= '0;
                brw         <= 1'b0;
                neq         <= 1'b0;
            end else if (state == RUN) begin
                cnt <= last ? '0 : cnt + 1'b1;
                brw <= bout;
                neq <= neq | (|diff);
                if (last) begin
                    C  <= N'(cond);
                    lt <= flt;
                    eq <= feq;
                    gt <= fgt;
                end
            end
        end
    end
endmodule

// File: tb/tb_cmp_mc.sv
// tb_cmp_mc: directed and random checks of cmp_mc against an arithmetic reference model
module tb_cmp_mc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  st = '0;
    logic [2:0]  md = '0;
    logic [31:0] a = '0, b = '0;
    logic        b0, b1, b2, v0, v1, v2, l0, l1, l2, e0, e1, e2, g0, g1, g2;
    logic [7:0]  c0;
    logic [31:0] c1, c2;
    int          sel = 0;
    logic [31:0] oc;
    logic        ob, ov;
    logic [2:0]  of;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    cmp_mc #(.N(8), .CHUNK(4)) d0 (
        .clk(clk), .rst(rst), .start(st[0]), .mode(md), .A(a[7:0]), .B(b[7:0]),
        .busy(b0), .valid(v0), .C(c0), .lt(l0), .eq(e0), .gt(g0));
    cmp_mc #(.N(32), .CHUNK(8)) d1 (
        .clk(clk), .rst(rst), .start(st[1]), .mode(md), .A(a), .B(b),
        .busy(b1), .valid(v1), .C(c1), .lt(l1), .eq(e1), .gt(g1));
    cmp_mc #(.N(32), .CHUNK(32)) d2 (
        .clk(clk), .rst(rst), .start(st[2]), .mode(md), .A(a), .B(b),
        .busy(b2), .valid(v2), .C(c2), .lt(l2), .eq(e2), .gt(g2));

    always_comb begin
        oc = sel == 0 ? {24'b0, c0} : sel == 1 ? c1 : c2;
        ob = sel == 0 ? b0 : sel == 1 ? b1 : b2;
        ov = sel == 0 ? v0 : sel == 1 ? v1 : v2;
        of = sel == 0 ? {l0, e0, g0} : sel == 1 ? {l1, e1, g1} : {l2, e2, g2};
    end

    function automatic int nch(input int d);
        return d == 0 ? 2 : d == 1 ? 4 : 1;
    endfunction

    // returns {cond, lt, eq, gt} from plain integer comparison
    function automatic logic [3:0] model(input logic [2:0] m, input logic [31:0] x, input logic [31:0] y, input int n);
        logic  sg, g, l, e, c;
        longint p, q;
        sg = m[0] && (m[2:1] != 2'b10);
        if (n == 8) begin
            p = sg ? longint'($signed(x[7:0])) : longint'({56'b0, x[7:0]});
            q = sg ? longint'($signed(y[7:0])) : longint'({56'b0, y[7:0]});
        end else begin
            p = sg ? longint'($signed(x)) : longint'({32'b0, x});
            q = sg ? longint'($signed(y)) : longint'({32'b0, y});
        end
        g = p > q;
        l = p < q;
        e = p == q;
        c = m < 2 ? g : m < 4 ? l : m == 4 ? e : m == 5 ? !e : (g | e);
        return {c, l, e, g};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic op(input int d, input logic [2:0] m, input logic [31:0] x, input logic [31:0] y);
        logic [3:0] r;
        int lat;
        r = model(m, x, y, d == 0 ? 8 : 32);
        @(negedge clk);
        sel = d; md = m; a = x; b = y; st = 3'b001 << d;
        @(negedge clk);
        st = '0;
        lat = 1;
        while (!ov && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(nch(d) + 1));
        chk("valid", {63'b0, ov}, 64'd1);
        chk("busy_at_valid", {63'b0, ob}, 64'd0);
        chk("C", {32'b0, oc}, {63'b0, r[3]});
        chk("flags", {61'b0, of}, {61'b0, r[2:0]});
        @(negedge clk);
        chk("valid_one_cycle", {63'b0, ov}, 64'd0);
    endtask

    logic [2:0]  qm[26];
    logic [31:0] qa[26], qb[26];

    initial begin
        int nv;
        logic [3:0] r;
        logic [31:0] x;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            sel = d;
            #1;
            chk("reset_state", {26'b0, ob, ov, of, 1'b0, oc}, 64'd0);
        end
        rst = 1'b0;
        op(0, 3'b000, 32'h05, 32'h03);
        op(0, 3'b001, 32'h80, 32'h01);
        op(0, 3'b000, 32'h80, 32'h01);
        op(0, 3'b011, 32'h80, 32'h01);
        for (int m = 4; m < 8; m++) op(0, 3'(m), 32'hA5, 32'hA5);
        op(0, 3'b001, 32'hA5, 32'hA5);
        op(2, 3'b111, 32'h7FFF_FFFF, 32'h8000_0000);
        op(2, 3'b110, 32'h7FFF_FFFF, 32'h8000_0000);
        // start while busy must be ignored
        @(negedge clk);
        sel = 0; md = 3'b000; a = 32'h05; b = 32'h03; st = 3'b001;
        @(negedge clk);
        md = 3'b010; a = 32'h00; b = 32'h00;
        @(negedge clk);
        st = '0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            if (ov) begin
                nv++;
                chk("busy_start_C", {32'b0, oc}, 64'd1);
                chk("busy_start_flags", {61'b0, of}, 64'b001);
            end
            @(negedge clk);
        end
        chk("busy_start_count", 64'(nv), 64'd1);
        // reset during RUN aborts and clears prior result
        op(0, 3'b100, 32'h5A, 32'h5A);
        @(negedge clk);
        md = 3'b000; a = 32'h05; b = 32'h03; st = 3'b001;
        @(negedge clk);
        st = '0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_run_state", {26'b0, ob, ov, of, 1'b0, oc}, 64'd0);
        nv = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            nv += int'(ov);
        end
        chk("rst_no_valid", 64'(nv), 64'd0);
        op(0, 3'b010, 32'h03, 32'h05);
        // continuous start on the 32/8 instance
        sel = 1;
        for (int j = 0; j < 26; j++) begin
            @(negedge clk);
            if (j >= 5 && j % 5 == 0) begin
                r = model(qm[j-5], qa[j-5], qb[j-5], 32);
                chk("stream_valid", {63'b0, ov}, 64'd1);
                chk("stream_C", {32'b0, oc}, {63'b0, r[3]});
                chk("stream_flags", {61'b0, of}, {61'b0, r[2:0]});
            end else begin
                chk("stream_novalid", {63'b0, ov}, 64'd0);
            end
            qm[j] = 3'($urandom);
            qa[j] = $urandom;
            qb[j] = j % 3 == 0 ? qa[j] : $urandom;
            md = qm[j]; a = qa[j]; b = qb[j]; st = 3'b010;
        end
        @(negedge clk);
        st = '0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            x = $urandom;
            op(0, 3'($urandom), x, i % 4 == 0 ? x : $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            x = $urandom;
            op(1, 3'($urandom), x, i % 3 == 0 ? x ^ 32'h8000_0000 : $urandom);
            op(2, 3'($urandom), x, i % 4 == 0 ? x : $urandom);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
